// File: rtl/ariane_pkg.sv
// ariane_pkg (slice)
// Purpose : shared core types and constants used by the branch-history update
//           path.
// Contents: VLEN            - virtual address width of a branch pc
//           BHT_UPD_DEPTH   - default depth of the BHT update buffer
//           bht_update_t    - one branch resolution (valid, pc, taken)
package ariane_pkg;

  localparam int unsigned VLEN          = 64;
  localparam int unsigned BHT_UPD_DEPTH = 4;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

endpackage

// File: rtl/bht_update_buffer.sv
// bht_update_buffer
// Purpose : small FIFO between branch resolution in execute and the BHT.
//           Resolutions are queued in order and drained one per cycle while
//           the BHT is ready. A new resolution whose pc is already queued (and
//           is not leaving this cycle) just refreshes that entry's taken bit,
//           so no two valid entries ever share a pc. Resolutions that find the
//           queue full are dropped and counted.
// Ports   : clk_i         - clock, all state on the rising edge
//           rst_i         - synchronous active-high reset
//           flush_i       - discard every queued entry (next cycle)
//           debug_mode_i  - block new pushes, queued entries keep draining
//           resolve_i     - branch resolution from execute
//           bht_ready_i   - BHT takes bht_update_o this cycle
//           bht_update_o  - head entry (all zero when empty)
//           fill_o        - occupancy, 0..DEPTH
//           drop_cnt_o    - saturating count of dropped resolutions
module bht_update_buffer
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH      = BHT_UPD_DEPTH,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     debug_mode_i,
  input  bht_update_t              resolve_i,
  input  logic                     bht_ready_i,
  output bht_update_t              bht_update_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_FILL = (PTR_W+1)'(DEPTH);

  logic [VLEN-1:0]       pc_q [DEPTH];
  logic [VLEN-1:0]       pc_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      taken_q, taken_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        fill_q, fill_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             push_req;
  logic             pop;
  logic             full;
  logic [DEPTH-1:0] match;
  logic             match_any;
  logic             enqueue;
  logic             drop;

  assign push_req = resolve_i.valid & ~debug_mode_i & ~flush_i;
  assign pop      = (fill_q != '0) & bht_ready_i;
  assign full     = (fill_q == FULL_FILL);

  // The head entry leaving this cycle is excluded from matching: a push with
  // its pc must become a fresh tail entry, otherwise the new outcome would be
  // lost together with the popped entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_q[gi] && (pc_q[gi] == resolve_i.pc) &&
                       !(pop && (rd_ptr_q == PTR_W'(gi)));
  end

  assign match_any = |match;
  assign enqueue   = push_req & ~match_any & (~full | pop);
  assign drop      = push_req & ~match_any & full & ~pop;

  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    taken_d    = taken_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    drop_cnt_d = drop_cnt_q;

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    // Coalesce in place: order and occupancy are untouched.
    if (push_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (match[i]) taken_d[i] = resolve_i.taken;
      end
    end

    // Applied after the pop so a full queue can pop and refill the same slot.
    if (enqueue) begin
      pc_d[wr_ptr_q]    = resolve_i.pc;
      taken_d[wr_ptr_q] = resolve_i.taken;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    fill_d = fill_q + (PTR_W+1)'(enqueue) - (PTR_W+1)'(pop);

    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end

    // Flush wins over everything except the drop counter.
    if (flush_i) begin
      valid_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      valid_q    <= '0;
      taken_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= pc_d[i];
      valid_q    <= valid_d;
      taken_q    <= taken_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Output comes from registered state only, so a push is never visible in
  // the cycle it arrives.
  always_comb begin
    bht_update_o = '0;
    if (fill_q != '0) begin
      bht_update_o.valid = 1'b1;
      bht_update_o.pc    = pc_q[rd_ptr_q];
      bht_update_o.taken = taken_q[rd_ptr_q];
    end
  end

  assign fill_o     = fill_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
